dilv2_deint: RTL

- Receive-side inverse of the 2-way lane interleaver in the SL3 FEC path.
- The transmitter splits each WIDTH-bit word into halves and delays the high half by one word. It then bit-interleaves the halves into odd and even channel bits.
- This block un-mixes the odd/even bits, delays the low half by one accepted word and re-joins the halves so original words come out in order.
- It adds valid-qualified streaming, a priming state machine after reset or resync, and a saturating count of recovered words.

---
 rtl/dilv2_deint.sv | 78 +++++++
 1 files changed

// File: rtl/dilv2_deint.sv
// Receive-side inverse of the SL3 2-way lane interleaver: un-mixes odd/even
// channel bits, realigns the low half by one accepted word and re-joins halves.
module dilv2_deint #(
  parameter int WIDTH = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             resync,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             primed,
  output logic [CNT_W-1:0] word_cnt
);
  localparam int HW = WIDTH / 2;

  generate
    if (WIDTH % 2 != 0) begin : g_width_chk
      $error("dilv2_deint: WIDTH must be even");
    end
  endgenerate

  typedef enum logic {PRIME, RUN} state_t;

  state_t           r_state;
  logic [HW-1:0]    r_prev_low;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic [CNT_W-1:0] r_word_cnt;
  logic [HW-1:0]    w_u_low;
  logic [HW-1:0]    w_u_high;

  // Even channel bits carry the current low half, odd bits the previous high half.
  always_comb begin
    w_u_low  = '0;
    w_u_high = '0;
    for (int i = 0; i < HW; i++) begin
      w_u_low[i]  = din[2*i];
      w_u_high[i] = din[2*i+1];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= PRIME;
      r_prev_low   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_word_cnt   <= '0;
    end else if (resync) begin
      r_state      <= PRIME;
      r_prev_low   <= '0;
      r_dout_valid <= 1'b0;
      r_word_cnt   <= '0;
    end else if (din_valid) begin
      r_prev_low <= w_u_low;
      if (r_state == PRIME) begin
        // High half of the priming word is the transmitter's stale initial value.
        r_state      <= RUN;
        r_dout_valid <= 1'b0;
      end else begin
        r_dout       <= {w_u_high, r_prev_low};
        r_dout_valid <= 1'b1;
        if (r_word_cnt != '1)
          r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign primed     = (r_state == RUN);
  assign word_cnt   = r_word_cnt;
endmodule
